// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data-memory load/store unit: req/gnt/rvalid bus master with load formatting
// Holds the pipeline via stall while a legal access is in flight; illegal accesses only raise fault.
module dmem_lsu (
   input  logic        Clock,
   input  logic        nReset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   input  logic        Rmem,
   input  logic        Wmem,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic [31:0] memOut,
   output logic        stall,
   output logic        fault
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state;
   logic [2:0]  cap_funct3;
   logic [1:0]  cap_lo;
   logic        illegal;
   logic        start;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;

   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = lo[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b100:  fmt_load = {24'b0, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b101:  fmt_load = {16'b0, h};
         default: fmt_load = d;
      endcase
   endfunction

   // Legality: stores allow only 000/001/010, loads additionally the unsigned 100/101.
   always_comb begin
      logic f3_ok;
      logic misalign;
      f3_ok    = 1'b0;
      misalign = 1'b0;
      if (Wmem)
         f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      else
         f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
      if (funct3[1:0] == 2'b01)
         misalign = addr[0];
      else if (funct3[1:0] == 2'b10)
         misalign = (addr[1:0] != 2'b00);
      illegal = (Rmem & Wmem) | ~f3_ok | misalign;
      fault   = (state == IDLE) & (Rmem | Wmem) & illegal;
      start   = (state == IDLE) & (Rmem | Wmem) & ~illegal;
      stall   = start | (state == REQ) | (state == RESP);
   end

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = wdata;
      if (Wmem) begin
         case (funct3[1:0])
            2'b00: begin
               be_next    = 4'b0001 << addr[1:0];
               wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
               be_next    = addr[1] ? 4'b1100 : 4'b0011;
               wdata_next = {2{wdata[15:0]}};
            end
            default: begin
               be_next    = 4'b1111;
               wdata_next = wdata;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state      <= IDLE;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'b0;
         bus_be     <= 4'b0;
         bus_wdata  <= 32'b0;
         memOut     <= 32'b0;
         cap_funct3 <= 3'b0;
         cap_lo     <= 2'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bus_req    <= 1'b1;
                  bus_we     <= Wmem;
                  bus_addr   <= {addr[31:2], 2'b00};
                  bus_be     <= be_next;
                  bus_wdata  <= wdata_next;
                  cap_funct3 <= funct3;
                  cap_lo     <= addr[1:0];
                  state      <= REQ;
               end
            end
            REQ: begin
               if (bus_gnt) begin
                  bus_req <= 1'b0;
                  state   <= bus_we ? DONE : RESP;
               end
            end
            RESP: begin
               if (bus_rvalid) begin
                  memOut <= fmt_load(cap_funct3, cap_lo, bus_rdata);
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;

   logic        Clock = 1'b0;
   logic        nReset;
   logic [31:0] addr, wdata;
   logic [2:0]  funct3;
   logic        Rmem, Wmem;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;
   logic [31:0] memOut;
   logic        stall, fault;

   int n_checks = 0;
   int n_pass   = 0;

   dmem_lsu dut (
      .Clock(Clock), .nReset(nReset), .addr(addr), .wdata(wdata), .funct3(funct3),
      .Rmem(Rmem), .Wmem(Wmem), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .memOut(memOut), .stall(stall), .fault(fault)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      Rmem = 0; Wmem = 0; addr = 0; wdata = 0; funct3 = 0;
   endtask

   task automatic store_txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] f3, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
      @(negedge Clock);
      addr = a; wdata = wd; funct3 = f3; Wmem = 1;
      #1 chk({tag, " idle stall"}, 32'(stall), 32'd1);
      chk({tag, " idle fault"}, 32'(fault), 32'd0);
      @(negedge Clock);
      chk({tag, " req"}, 32'(bus_req), 32'd1);
      chk({tag, " we"}, 32'(bus_we), 32'd1);
      chk({tag, " addr"}, bus_addr, {a[31:2], 2'b00});
      chk({tag, " be"}, 32'(bus_be), 32'(exp_be));
      chk({tag, " wdata"}, bus_wdata, exp_wd);
      chk({tag, " req stall"}, 32'(stall), 32'd1);
      bus_gnt = 1; Wmem = 0; addr = 32'hFFFF_FFFF;
      @(negedge Clock);
      bus_gnt = 0;
      chk({tag, " done stall"}, 32'(stall), 32'd0);
      chk({tag, " done req"}, 32'(bus_req), 32'd0);
      idle_inputs();
   endtask

   task automatic load_txn(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rd, input int rv_delay, input logic [31:0] exp);
      @(negedge Clock);
      addr = a; funct3 = f3; Rmem = 1;
      #1 chk({tag, " idle stall"}, 32'(stall), 32'd1);
      @(negedge Clock);
      chk({tag, " req"}, 32'(bus_req), 32'd1);
      chk({tag, " we"}, 32'(bus_we), 32'd0);
      chk({tag, " be"}, 32'(bus_be), 32'hF);
      chk({tag, " addr"}, bus_addr, {a[31:2], 2'b00});
      bus_gnt = 1; Rmem = 0; addr = 32'hFFFF_FFFF; funct3 = 3'b010;
      @(negedge Clock);
      bus_gnt = 0;
      chk({tag, " resp req"}, 32'(bus_req), 32'd0);
      for (int i = 0; i < rv_delay; i++) begin
         chk({tag, " resp stall"}, 32'(stall), 32'd1);
         @(negedge Clock);
      end
      bus_rvalid = 1; bus_rdata = rd;
      @(negedge Clock);
      bus_rvalid = 0; bus_rdata = 32'h0;
      chk({tag, " done stall"}, 32'(stall), 32'd0);
      chk({tag, " memOut"}, memOut, exp);
      idle_inputs();
   endtask

   task automatic fault_case(input string tag, input logic rm, input logic wm,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp_mem);
      @(negedge Clock);
      Rmem = rm; Wmem = wm; funct3 = f3; addr = a;
      #1 chk({tag, " fault"}, 32'(fault), 32'd1);
      chk({tag, " stall"}, 32'(stall), 32'd0);
      @(negedge Clock);
      chk({tag, " no req"}, 32'(bus_req), 32'd0);
      chk({tag, " memOut held"}, memOut, exp_mem);
      chk({tag, " fault held"}, 32'(fault), 32'd1);
      idle_inputs();
   endtask

   initial begin
      nReset = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
      idle_inputs();
      repeat (2) @(negedge Clock);
      chk("rst req", 32'(bus_req), 32'd0);
      chk("rst we", 32'(bus_we), 32'd0);
      chk("rst addr", bus_addr, 32'd0);
      chk("rst be", 32'(bus_be), 32'd0);
      chk("rst wdata", bus_wdata, 32'd0);
      chk("rst memOut", memOut, 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst fault", 32'(fault), 32'd0);
      nReset = 1;

      store_txn("SW", 32'h100, 32'hDEADBEEF, 3'b010, 4'b1111, 32'hDEADBEEF);
      store_txn("SB", 32'h103, 32'h000000A5, 3'b000, 4'b1000, 32'hA5A5A5A5);
      store_txn("SH", 32'h102, 32'h00001234, 3'b001, 4'b1100, 32'h12341234);

      // rvalid outside RESP must not touch memOut
      @(negedge Clock);
      bus_rvalid = 1; bus_rdata = 32'h5555_5555;
      @(negedge Clock);
      bus_rvalid = 0;
      chk("stray rvalid", memOut, 32'd0);

      load_txn("LB", 32'h102, 3'b000, 32'h12F03456, 2, 32'hFFFFFFF0);
      load_txn("LBU", 32'h102, 3'b100, 32'h12F03456, 0, 32'h000000F0);
      load_txn("LH", 32'h102, 3'b001, 32'h80001234, 1, 32'hFFFF8000);
      load_txn("LHU", 32'h102, 3'b101, 32'h80001234, 0, 32'h00008000);

      fault_case("LW mis", 1, 0, 3'b010, 32'h101, 32'h00008000);
      fault_case("SH mis", 0, 1, 3'b001, 32'h103, 32'h00008000);
      fault_case("R&W", 1, 1, 3'b010, 32'h100, 32'h00008000);
      fault_case("LD f3", 1, 0, 3'b011, 32'h100, 32'h00008000);
      fault_case("ST f3", 0, 1, 3'b100, 32'h100, 32'h00008000);

      store_txn("SW after", 32'h10, 32'h01020304, 3'b010, 4'b1111, 32'h01020304);
      chk("memOut across store", memOut, 32'h00008000);

      // gnt withheld, then reset while in REQ
      @(negedge Clock);
      addr = 32'h204; wdata = 32'h11223344; funct3 = 3'b010; Wmem = 1;
      @(negedge Clock);
      Wmem = 0; addr = 0;
      for (int i = 0; i < 5; i++) begin
         chk("hold req", 32'(bus_req), 32'd1);
         chk("hold addr", bus_addr, 32'h204);
         chk("hold wdata", bus_wdata, 32'h11223344);
         @(negedge Clock);
      end
      nReset = 0;
      #1;
      chk("mid rst req", 32'(bus_req), 32'd0);
      chk("mid rst addr", bus_addr, 32'd0);
      chk("mid rst be", 32'(bus_be), 32'd0);
      chk("mid rst wdata", bus_wdata, 32'd0);
      chk("mid rst memOut", memOut, 32'd0);
      chk("mid rst stall", 32'(stall), 32'd0);
      @(negedge Clock);
      nReset = 1;
      @(negedge Clock);
      chk("post rst req", 32'(bus_req), 32'd0);
      chk("post rst stall", 32'(stall), 32'd0);

      load_txn("LW", 32'h104, 3'b010, 32'hCAFEBABE, 0, 32'hCAFEBABE);
      @(negedge Clock);
      chk("LW memOut hold", memOut, 32'hCAFEBABE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
